// File: rtl/h264_quantise_pkg.sv
// Shared constants for the H.264 forward quantiser: MF table, zigzag position
// classes and QP/6, QP%6 lookups.
package h264_pkg;

    localparam int unsigned QP_MAX = 51;

    typedef enum logic [1:0] {CLS_A, CLS_B, CLS_C} pos_class_e;

    typedef enum logic {StIdle, StBlock} blk_state_e;

    // Rows by qp%6, columns by position class A, B, C.
    localparam logic [13:0] MF_TABLE [6][3] = '{
        '{14'd13107, 14'd5243, 14'd8066},
        '{14'd11916, 14'd4660, 14'd7490},
        '{14'd10082, 14'd4194, 14'd6554},
        '{14'd9362,  14'd3647, 14'd5825},
        '{14'd8192,  14'd3355, 14'd5243},
        '{14'd7282,  14'd2893, 14'd4559}
    };

    localparam pos_class_e ZZ_CLASS [16] = '{
        CLS_A, CLS_C, CLS_C, CLS_A, CLS_B, CLS_A, CLS_C, CLS_C,
        CLS_C, CLS_C, CLS_B, CLS_A, CLS_B, CLS_C, CLS_C, CLS_B
    };

    // floor(2^23/3); shifting right by (23-qbits) yields floor(2^qbits/3).
    localparam logic [21:0] F_INTRA_MAX = 22'h2AAAAA;

    function automatic logic [3:0] qp_div6(input logic [5:0] qp);
        logic [3:0] d;
        d = 4'd8;
        case (qp) inside
            [6'd0:6'd5]:   d = 4'd0;
            [6'd6:6'd11]:  d = 4'd1;
            [6'd12:6'd17]: d = 4'd2;
            [6'd18:6'd23]: d = 4'd3;
            [6'd24:6'd29]: d = 4'd4;
            [6'd30:6'd35]: d = 4'd5;
            [6'd36:6'd41]: d = 4'd6;
            [6'd42:6'd47]: d = 4'd7;
            default:       d = 4'd8;
        endcase
        return d;
    endfunction

    function automatic logic [2:0] qp_mod6(input logic [5:0] qp);
        return 3'(qp - 6'(qp_div6(qp)) * 6'd6);
    endfunction

endpackage

// File: rtl/h264_quantise_if.sv
// Coefficient-in / level-out bus of the quantiser.
interface h264_quantise_if #(
    parameter int unsigned IN_W  = 14,
    parameter int unsigned OUT_W = 12
);
    logic             VALID_IN;
    logic [IN_W-1:0]  YNIN;
    logic [5:0]       QP;
    logic             INTRA;
    logic             VALID_OUT;
    logic [OUT_W-1:0] ZOUT;
    logic             BLOCK_DONE;
    logic [4:0]       NZCOUNT;

    modport master (
        output VALID_IN, YNIN, QP, INTRA,
        input  VALID_OUT, ZOUT, BLOCK_DONE, NZCOUNT
    );

    modport slave (
        input  VALID_IN, YNIN, QP, INTRA,
        output VALID_OUT, ZOUT, BLOCK_DONE, NZCOUNT
    );
endinterface

// File: rtl/h264_quant_mf_rom.sv
// Combinational MF lookup by (qp%6, position class).
module h264_quant_mf_rom
    import h264_pkg::*;
(
    input  logic [2:0]  qp_mod_i,
    input  pos_class_e  cls_i,
    output logic [13:0] mf_o
);

    always_comb begin
        mf_o = '0;
        if (qp_mod_i < 3'd6) begin
            unique case (cls_i)
                CLS_A:   mf_o = MF_TABLE[qp_mod_i][0];
                CLS_B:   mf_o = MF_TABLE[qp_mod_i][1];
                CLS_C:   mf_o = MF_TABLE[qp_mod_i][2];
                default: mf_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/h264_quantise.sv
// H.264 forward quantiser: 3-stage pipeline from transform coefficient to
// saturated level, with per-block nonzero count.
module h264_quantise
    import h264_pkg::*;
#(
    parameter int unsigned IN_W      = 14,
    parameter int unsigned OUT_W     = 12,
    parameter int unsigned LEVEL_MAX = 2047
) (
    input logic             CLK,
    input logic             RESET,
    h264_quantise_if.slave  bus
);

    localparam int unsigned MF_W   = 14;
    localparam int unsigned F_W    = 22;
    localparam int unsigned SUM_W  = IN_W + MF_W + 1;

    blk_state_e state_q, state_d;
    logic [3:0] k_q, k_d;
    logic [5:0] qp_l_q, qp_l_d;
    logic       intra_l_q, intra_l_d;

    logic [5:0]     qp_clamp, qp_eff;
    logic           intra_eff;
    logic [3:0]     qp_div;
    logic [2:0]     qp_mod;
    logic [MF_W-1:0] mf;
    logic [F_W-1:0] f_intra;

    logic            v1_q, v1_d, sign1_q, sign1_d, last1_q, last1_d;
    logic [IN_W-1:0] abs1_q, abs1_d;
    logic [MF_W-1:0] mf1_q, mf1_d;
    logic [4:0]      qbits1_q, qbits1_d;
    logic [F_W-1:0]  f1_q, f1_d;

    logic             v2_q, v2_d, sign2_q, sign2_d, last2_q, last2_d;
    logic [SUM_W-1:0] sum2_q, sum2_d;
    logic [4:0]       qbits2_q, qbits2_d;

    logic             valid_out_q, valid_out_d, block_done_q, block_done_d;
    logic [OUT_W-1:0] zout_q, zout_d;
    logic [4:0]       nzcount_q, nzcount_d, nz_acc_q, nz_acc_d;

    logic [SUM_W-1:0] shifted;
    logic [OUT_W-1:0] mag, level;
    logic             nz_inc;

    // Coefficient 0 uses the live QP/INTRA; the rest of the block uses the latch.
    always_comb begin
        qp_clamp  = (bus.QP > 6'(QP_MAX)) ? 6'(QP_MAX) : bus.QP;
        qp_eff    = (state_q == StIdle) ? qp_clamp : qp_l_q;
        intra_eff = (state_q == StIdle) ? bus.INTRA : intra_l_q;
        qp_div    = qp_div6(qp_eff);
        qp_mod    = qp_mod6(qp_eff);
        f_intra   = F_INTRA_MAX >> (4'd8 - qp_div);
    end

    h264_quant_mf_rom u_mf_rom (
        .qp_mod_i (qp_mod),
        .cls_i    (ZZ_CLASS[k_q]),
        .mf_o     (mf)
    );

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        qp_l_d    = qp_l_q;
        intra_l_d = intra_l_q;
        unique case (state_q)
            StIdle: begin
                if (bus.VALID_IN) begin
                    state_d   = StBlock;
                    k_d       = 4'd1;
                    qp_l_d    = qp_clamp;
                    intra_l_d = bus.INTRA;
                end
            end
            StBlock: begin
                if (bus.VALID_IN) begin
                    k_d = k_q + 4'd1;
                    if (k_q == 4'd15) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        v1_d     = bus.VALID_IN;
        abs1_d   = abs1_q;
        sign1_d  = sign1_q;
        mf1_d    = mf1_q;
        qbits1_d = qbits1_q;
        f1_d     = f1_q;
        last1_d  = last1_q;
        if (bus.VALID_IN) begin
            sign1_d  = bus.YNIN[IN_W-1];
            abs1_d   = bus.YNIN[IN_W-1] ? (~bus.YNIN + 1'b1) : bus.YNIN;
            mf1_d    = mf;
            qbits1_d = 5'd15 + 5'(qp_div);
            f1_d     = intra_eff ? f_intra : (f_intra >> 1);
            last1_d  = (k_q == 4'd15);
        end
    end

    always_comb begin
        v2_d     = v1_q;
        sum2_d   = sum2_q;
        sign2_d  = sign2_q;
        qbits2_d = qbits2_q;
        last2_d  = last2_q;
        if (v1_q) begin
            sum2_d   = SUM_W'(abs1_q) * SUM_W'(mf1_q) + SUM_W'(f1_q);
            sign2_d  = sign1_q;
            qbits2_d = qbits1_q;
            last2_d  = last1_q;
        end
    end

    always_comb begin
        shifted = sum2_q >> qbits2_q;
        mag     = (shifted > SUM_W'(LEVEL_MAX)) ? OUT_W'(LEVEL_MAX) : shifted[OUT_W-1:0];
        level   = sign2_q ? -mag : mag;
        nz_inc  = (mag != '0);

        valid_out_d  = v2_q;
        block_done_d = v2_q && last2_q;
        zout_d       = zout_q;
        nzcount_d    = nzcount_q;
        nz_acc_d     = nz_acc_q;
        if (v2_q) begin
            zout_d = level;
            if (last2_q) begin
                nzcount_d = nz_acc_q + 5'(nz_inc);
                nz_acc_d  = '0;
            end else begin
                nz_acc_d  = nz_acc_q + 5'(nz_inc);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q      <= StIdle;
            k_q          <= '0;
            qp_l_q       <= '0;
            intra_l_q    <= 1'b0;
            v1_q         <= 1'b0;
            abs1_q       <= '0;
            sign1_q      <= 1'b0;
            mf1_q        <= '0;
            qbits1_q     <= '0;
            f1_q         <= '0;
            last1_q      <= 1'b0;
            v2_q         <= 1'b0;
            sum2_q       <= '0;
            sign2_q      <= 1'b0;
            qbits2_q     <= '0;
            last2_q      <= 1'b0;
            valid_out_q  <= 1'b0;
            block_done_q <= 1'b0;
            zout_q       <= '0;
            nzcount_q    <= '0;
            nz_acc_q     <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            qp_l_q       <= qp_l_d;
            intra_l_q    <= intra_l_d;
            v1_q         <= v1_d;
            abs1_q       <= abs1_d;
            sign1_q      <= sign1_d;
            mf1_q        <= mf1_d;
            qbits1_q     <= qbits1_d;
            f1_q         <= f1_d;
            last1_q      <= last1_d;
            v2_q         <= v2_d;
            sum2_q       <= sum2_d;
            sign2_q      <= sign2_d;
            qbits2_q     <= qbits2_d;
            last2_q      <= last2_d;
            valid_out_q  <= valid_out_d;
            block_done_q <= block_done_d;
            zout_q       <= zout_d;
            nzcount_q    <= nzcount_d;
            nz_acc_q     <= nz_acc_d;
        end
    end

    assign bus.VALID_OUT  = valid_out_q;
    assign bus.ZOUT       = zout_q;
    assign bus.BLOCK_DONE = block_done_q;
    assign bus.NZCOUNT    = nzcount_q;

endmodule

// File: tb/tb_h264_quantise.sv
// Directed-vector bench for h264_quantise: expected levels are hand-computed,
// a negedge monitor checks level, latency, BLOCK_DONE and NZCOUNT.
module tb_h264_quantise;

    typedef struct {
        logic [5:0]          qp;
        logic                intra;
        int                  k;
        logic signed [13:0]  y;
        logic signed [11:0]  lvl;
    } vec_t;

    typedef struct {
        logic signed [11:0] lvl;
        int                 due;
        logic               last;
        int                 nz;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    always #5 CLK = ~CLK;

    h264_quantise_if bus ();

    h264_quantise #(
        .IN_W      (14),
        .OUT_W     (12),
        .LEVEL_MAX (2047)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    exp_t exp_q[$];
    logic signed [11:0] last_z = '0;

    vec_t tbl [15];
    logic signed [13:0] blk_y [16];
    logic signed [11:0] blk_e [16];
    logic [5:0]         blk_qp [16];
    logic               blk_intra [16];
    // Levels for Y=100 at QP=0 intra, by class A=40, B=16, C=24.
    int hundred_lvl [16] = '{40, 24, 24, 40, 16, 40, 24, 24, 24, 24, 16, 40, 16, 24, 24, 16};

    task automatic chk(input bit ok, input string name, input int act, input int req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge CLK) begin : mon
        exp_t e;
        if (bus.VALID_OUT) begin
            if (exp_q.size() == 0) begin
                chk(1'b0, "unexpected_valid_out", int'($signed(bus.ZOUT)), 0);
            end else begin
                e = exp_q.pop_front();
                chk($signed(bus.ZOUT) == e.lvl, "zout", int'($signed(bus.ZOUT)), int'(e.lvl));
                chk(cyc == e.due, "latency", cyc, e.due);
                chk(bus.BLOCK_DONE == e.last, "block_done", int'(bus.BLOCK_DONE), int'(e.last));
                if (e.last) chk(int'(bus.NZCOUNT) == e.nz, "nzcount", int'(bus.NZCOUNT), e.nz);
            end
        end else begin
            chk($signed(bus.ZOUT) == last_z, "zout_hold", int'($signed(bus.ZOUT)), int'(last_z));
            chk(bus.BLOCK_DONE == 1'b0, "block_done_idle", int'(bus.BLOCK_DONE), 0);
        end
        last_z = $signed(bus.ZOUT);
        if (!RESET) last_z = '0;
    end

    task automatic send(input logic signed [13:0] y, input logic [5:0] qp, input logic intra,
                        input logic signed [11:0] lvl, input logic last, input int nz);
        exp_t e;
        @(posedge CLK);
        #2;
        bus.VALID_IN = 1'b1;
        bus.YNIN     = y;
        bus.QP       = qp;
        bus.INTRA    = intra;
        e.lvl  = lvl;
        e.due  = cyc + 3;
        e.last = last;
        e.nz   = nz;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #2;
            bus.VALID_IN = 1'b0;
            bus.YNIN     = 14'h1555;
            bus.QP       = 6'd63;
        end
    endtask

    task automatic clr_blk(input logic [5:0] qp, input logic intra);
        for (int i = 0; i < 16; i++) begin
            blk_y[i]     = '0;
            blk_e[i]     = '0;
            blk_qp[i]    = qp;
            blk_intra[i] = intra;
        end
    endtask

    task automatic run_block(input int gapmax);
        int nz;
        nz = 0;
        for (int i = 0; i < 16; i++) if (blk_e[i] != 0) nz++;
        for (int i = 0; i < 16; i++) begin
            if (i > 0 && gapmax > 0) idle(int'($urandom_range(gapmax)));
            send(blk_y[i], blk_qp[i], blk_intra[i], blk_e[i], i == 15, nz);
        end
    endtask

    task automatic load_basic();
        clr_blk(6'd0, 1'b1);
        blk_y[0] = 14'sd100;
        blk_e[0] = 12'sd40;
        blk_y[4] = -14'sd100;
        blk_e[4] = -12'sd16;
    endtask

    task automatic load_hundred();
        clr_blk(6'd0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            blk_y[i] = 14'sd100;
            blk_e[i] = 12'(hundred_lvl[i]);
        end
    endtask

    initial begin
        tbl[0]  = '{6'd0,  1'b1, 0,  14'sd100,   12'sd40};
        tbl[1]  = '{6'd0,  1'b1, 4,  -14'sd100,  -12'sd16};
        tbl[2]  = '{6'd0,  1'b1, 0,  14'sd8191,  12'sd2047};
        tbl[3]  = '{6'd0,  1'b1, 0,  -14'sd8192, -12'sd2047};
        tbl[4]  = '{6'd6,  1'b0, 1,  14'sd50,    12'sd6};
        tbl[5]  = '{6'd28, 1'b1, 0,  14'sd0,     12'sd0};
        tbl[6]  = '{6'd60, 1'b1, 0,  14'sd8191,  12'sd9};
        tbl[7]  = '{6'd12, 1'b1, 2,  -14'sd1000, -12'sd61};
        tbl[8]  = '{6'd29, 1'b0, 15, 14'sd3000,  12'sd16};
        tbl[9]  = '{6'd17, 1'b1, 11, -14'sd200,  -12'sd11};
        tbl[10] = '{6'd0,  1'b1, 0,  14'sd2,     12'sd1};
        tbl[11] = '{6'd0,  1'b0, 0,  14'sd2,     12'sd0};
        tbl[12] = '{6'd3,  1'b1, 5,  14'sd500,   12'sd143};
        tbl[13] = '{6'd40, 1'b0, 7,  -14'sd8192, -12'sd20};
        tbl[14] = '{6'd51, 1'b1, 12, 14'sd8191,  12'sd3};

        bus.VALID_IN = 1'b0;
        bus.YNIN     = '0;
        bus.QP       = '0;
        bus.INTRA    = 1'b0;
        RESET        = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        chk(bus.VALID_OUT == 1'b0, "rst_valid_out", int'(bus.VALID_OUT), 0);
        chk(bus.ZOUT == '0, "rst_zout", int'($signed(bus.ZOUT)), 0);
        chk(bus.BLOCK_DONE == 1'b0, "rst_block_done", int'(bus.BLOCK_DONE), 0);
        chk(bus.NZCOUNT == '0, "rst_nzcount", int'(bus.NZCOUNT), 0);
        RESET = 1'b1;

        // One block per vector; non-zero positions carry different QP/INTRA to prove the latch.
        for (int v = 0; v < 15; v++) begin
            clr_blk(tbl[v].qp ^ 6'h15, ~tbl[v].intra);
            blk_qp[0]    = tbl[v].qp;
            blk_intra[0] = tbl[v].intra;
            blk_y[tbl[v].k] = tbl[v].y;
            blk_e[tbl[v].k] = tbl[v].lvl;
            run_block(0);
            idle(2);
        end

        load_basic();
        run_block(0);
        idle(4);

        // QP/INTRA change mid-block must not affect k2.
        clr_blk(6'd51, 1'b1);
        blk_qp[0] = 6'd6;
        blk_intra[0] = 1'b0;
        blk_qp[1] = 6'd6;
        blk_intra[1] = 1'b0;
        blk_y[1] = 14'sd50;
        blk_e[1] = 12'sd6;
        blk_y[2] = 14'sd50;
        blk_e[2] = 12'sd6;
        run_block(0);
        idle(4);

        load_hundred();
        run_block(0);
        idle(3);
        run_block(3);
        idle(3);
        load_basic();
        run_block(3);
        idle(4);

        load_basic();
        run_block(0);
        load_hundred();
        run_block(0);
        load_basic();
        run_block(0);
        idle(6);

        load_hundred();
        for (int i = 0; i < 8; i++) send(blk_y[i], 6'd0, 1'b1, blk_e[i], 1'b0, 0);
        @(posedge CLK);
        #2;
        RESET = 1'b0;
        bus.VALID_IN = 1'b0;
        for (int i = exp_q.size() - 1; i >= 0; i--) if (exp_q[i].due > cyc) exp_q.delete(i);
        repeat (2) @(posedge CLK);
        #2;
        RESET = 1'b1;
        idle(4);
        chk(bus.VALID_OUT == 1'b0, "post_rst_valid_out", int'(bus.VALID_OUT), 0);
        chk(bus.ZOUT == '0, "post_rst_zout", int'($signed(bus.ZOUT)), 0);
        chk(bus.NZCOUNT == '0, "post_rst_nzcount", int'(bus.NZCOUNT), 0);
        load_basic();
        run_block(0);
        load_hundred();
        run_block(1);
        idle(1);

        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge CLK);
        chk(exp_q.size() == 0, "drain", exp_q.size(), 0);
        repeat (4) @(posedge CLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/h264_quantise.md
Name: h264_quantise

Overview:
- Forward quantiser directly downstream of the 4x4 core transform.
- Consumes one 14-bit signed transform coefficient per VALID_IN strobe, in zigzag order, 16 per block.
- Applies H.264 scalar quantisation: MF table selected by QP%6 and coefficient position, shift by QP/6.
- Emits saturated 12-bit levels in the same order, toward CAVLC, with a per-block nonzero count.

Parameters:
- IN_W, 14, input coefficient width (signed)
- OUT_W, 12, output level width (signed)
- LEVEL_MAX, 2047, saturation magnitude for output levels

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-low reset
- VALID_IN  in  1  coefficient strobe
- YNIN  in  IN_W  transform coefficient, zigzag order, signed
- QP  in  6  quantiser parameter; sampled only with coefficient 0
- INTRA  in  1  rounding mode; sampled only with coefficient 0
- VALID_OUT  out  1  level strobe
- ZOUT  out  OUT_W  quantised level, signed
- BLOCK_DONE  out  1  pulses with the 16th level of a block
- NZCOUNT  out  5  nonzero levels in the block; valid when BLOCK_DONE=1

Behaviour:
- Reset values:
  - all outputs 0.
  - coefficient index k=0; pipeline valid bits 0; latched qp=0, intra=0.
  - NZ accumulator 0.
- Reset mid-block discards partial block and in-flight pipeline contents; no VALID_OUT afterwards until new input.
- Index/state:
  - Two states. IDLE (k=0): awaiting coefficient 0. BLOCK (k=1..15).
  - k increments on each VALID_IN and wraps 15->0 (BLOCK->IDLE).
  - VALID_IN gaps of any length are allowed; k holds during gaps.
- Parameter latch:
  - On VALID_IN with k=0: qp_l = min(QP,51) and intra_l = INTRA.
  - QP/INTRA changes at k!=0 are ignored for the rest of the block.
  - Coefficient 0 uses the new QP/INTRA values directly.
- Position class per k:
  - class A = k in {0,3,5,11}
  - class B = k in {4,10,12,15}
  - class C = all other k
- MF table, [A,B,C] by qp%6:
  - 0: 13107,5243,8066
  - 1: 11916,4660,7490
  - 2: 10082,4194,6554
  - 3: 9362,3647,5825
  - 4: 8192,3355,5243
  - 5: 7282,2893,4559
- Arithmetic:
  - qbits = 15 + qp/6 (range 15..23).
  - f = floor(2^qbits/3) when intra, floor(2^qbits/6) when inter.
  - |Y| takes 14 bits unsigned (8192 representable).
  - Product |Y|*MF uses 28 bits; adding f gives a 29-bit sum.
  - mag = (|Y|*MF + f) >> qbits, saturated to LEVEL_MAX.
  - ZOUT = -mag if Y<0, else mag. Result is never -0.
- Pipeline, fixed latency 3 cycles from VALID_IN to VALID_OUT. No backpressure.
  - S1 registers: abs, sign, MF, qbits, f, last flag (k==15).
  - S2 registers: product plus f.
  - S3 registers: shift, saturate, sign restore. Drives ZOUT and VALID_OUT.
- ZOUT holds its last value when VALID_OUT=0.
- NZ accumulation:
  - Counts ZOUT!=0 at S3.
  - At the last level: NZCOUNT = accumulator including that level (0..16); BLOCK_DONE=1 for one cycle; accumulator clears to 0.
  - NZCOUNT holds until the next BLOCK_DONE.
- Back-to-back blocks must produce correct NZCOUNT per block. Coefficient 0 of block n+1 may enter S1 in the cycle the last coefficient of block n leaves S3.

Decomposition:
- Shared package h264_pkg:
  - MF table as a constant array [6][3]
  - position-class enum {CLS_A, CLS_B, CLS_C}
  - zigzag-index to class constant array [16]
  - QP_MAX=51
- Sub-module h264_quant_mf_rom: combinational. Takes (qp%6, class) and returns MF (14 bit).
- qp/6 and qp%6 use a small constant lookup in h264_pkg, not a divider.

Test Plan:
- Zero block: QP=28, INTRA=1, 16 zeros contiguous -> 16 ZOUT=0 at +3 cycles; BLOCK_DONE with 16th; NZCOUNT=0.
- Basic scaling: QP=0, INTRA=1.
  - k0 Y=100 -> ZOUT=40.
  - k4 Y=-100 -> ZOUT=-16.
  - All other Y=0 -> NZCOUNT=2.
- Saturation: QP=0, INTRA=1, k0 Y=8191 -> 3276 before saturation -> ZOUT=2047; k0 Y=-8192 -> ZOUT=-2047.
- Inter rounding and QP latch: QP=6, INTRA=0, k1 Y=50 -> ZOUT=6. Change QP to 51 at k2, k2 Y=50 -> ZOUT still uses QP=6 -> 6.
- Gaps and back-to-back:
  - Random 0-3 cycle VALID_IN gaps within a block -> levels identical to contiguous run.
  - Two contiguous blocks -> each gets its own BLOCK_DONE/NZCOUNT.
  - QP=60 -> behaves as 51.
- Reset mid-block: RESET=0 after k=7 -> outputs 0, no further VALID_OUT. Next block restarts at k=0 with correct classes and NZCOUNT.
